// File: rtl/cpu_pkg.sv
// Shared CPU datapath types and sizing for the integer register file.
package cpu_pkg;
    localparam int DATA_WIDTH              = 32;
    localparam int NUM_REGISTERS           = 32;
    localparam int REGISTER_INDEXING_WIDTH = $clog2(NUM_REGISTERS);
    localparam int MAX_PENDING             = 3;
    localparam int PENDING_WIDTH           = $clog2(MAX_PENDING + 1);

    typedef logic [DATA_WIDTH-1:0]              data_t;
    typedef logic [REGISTER_INDEXING_WIDTH-1:0] reg_index_t;
    typedef logic [PENDING_WIDTH-1:0]           pending_t;
endpackage

// File: rtl/register_pending_counter.sv
// Outstanding-write counter for one architectural register, with a sticky
// flag raised when a writeback arrives that nothing had reserved.
module register_pending_counter
    import cpu_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    input  logic clear,
    output logic at_max,
    output logic is_zero,
    output logic is_one,
    output logic underflow
);
    pending_t count_q, count_d;
    logic     underflow_q, underflow_d;

    always_comb begin
        count_d     = count_q;
        underflow_d = 1'b0;
        // Flush wins outright, so a release racing a squash is never an error.
        if (clear) begin
            count_d = '0;
        end else if (inc && !dec) begin
            count_d = count_q + pending_t'(1);
        end else if (dec && !inc) begin
            if (count_q == '0) underflow_d = 1'b1;
            else               count_d     = count_q - pending_t'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            underflow_q <= underflow_q | underflow_d;
        end
    end

    assign at_max    = (count_q == pending_t'(MAX_PENDING));
    assign is_zero   = (count_q == '0);
    assign is_one    = (count_q == pending_t'(1));
    assign underflow = underflow_q;
endmodule

// File: rtl/register_file_scoreboard.sv
// Integer register file with per-register pending-write scoreboard and two
// combinational read ports that forward a same-cycle writeback.
module register_file_scoreboard
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  reg_index_t write_register,
    input  data_t      write_data,
    input  logic       write_activate,
    input  reg_index_t reserve_register,
    input  logic       reserve_activate,
    output logic       reserve_ready,
    input  logic       flush,
    input  reg_index_t read_register_a,
    output data_t      read_data_a,
    output logic       read_ready_a,
    input  reg_index_t read_register_b,
    output data_t      read_data_b,
    output logic       read_ready_b,
    output logic       underflow_error
);
    data_t regs_q [NUM_REGISTERS];

    logic                     write_en;
    logic [NUM_REGISTERS-1:0] release_vec;
    logic [NUM_REGISTERS-1:0] inc_vec;
    logic [NUM_REGISTERS-1:0] max_vec;
    logic [NUM_REGISTERS-1:0] zero_vec;
    logic [NUM_REGISTERS-1:0] one_vec;
    logic [NUM_REGISTERS-1:0] uf_vec;

    assign write_en = write_activate && (write_register != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGISTERS; i++) regs_q[i] <= '0;
        end else if (write_en) begin
            regs_q[write_register] <= write_data;
        end
    end

    // x0 behaves as a counter that is permanently empty and never saturates.
    assign release_vec[0] = 1'b0;
    assign inc_vec[0]     = 1'b0;
    assign max_vec[0]     = 1'b0;
    assign zero_vec[0]    = 1'b1;
    assign one_vec[0]     = 1'b0;
    assign uf_vec[0]      = 1'b0;

    generate
        for (genvar gi = 1; gi < NUM_REGISTERS; gi++) begin : g_pending
            assign release_vec[gi] = write_activate && (write_register == reg_index_t'(gi));
            assign inc_vec[gi]     = reserve_ready && (reserve_register == reg_index_t'(gi));

            register_pending_counter u_counter (
                .clk       (clk),
                .rst       (rst),
                .inc       (inc_vec[gi]),
                .dec       (release_vec[gi]),
                .clear     (flush),
                .at_max    (max_vec[gi]),
                .is_zero   (zero_vec[gi]),
                .is_one    (one_vec[gi]),
                .underflow (uf_vec[gi])
            );
        end
    endgenerate

    // A full counter can still accept when its release lands in the same cycle.
    assign reserve_ready = reserve_activate &&
                           (!max_vec[reserve_register] || release_vec[reserve_register]);

    assign read_data_a  = (read_register_a == '0) ? '0 :
                          (write_en && write_register == read_register_a) ? write_data :
                          regs_q[read_register_a];
    assign read_ready_a = zero_vec[read_register_a] ||
                          (one_vec[read_register_a] && release_vec[read_register_a]);

    assign read_data_b  = (read_register_b == '0) ? '0 :
                          (write_en && write_register == read_register_b) ? write_data :
                          regs_q[read_register_b];
    assign read_ready_b = zero_vec[read_register_b] ||
                          (one_vec[read_register_b] && release_vec[read_register_b]);

    assign underflow_error = |uf_vec;
endmodule

// File: tb/tb_register_file_scoreboard.sv
// Randomized and directed checks of register_file_scoreboard against an
// array-based reference model of registers, pending counts and the error flag.
module tb_register_file_scoreboard;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  write_register;
    logic [31:0] write_data;
    logic        write_activate;
    logic [4:0]  reserve_register;
    logic        reserve_activate;
    logic        reserve_ready;
    logic        flush;
    logic [4:0]  read_register_a;
    logic [31:0] read_data_a;
    logic        read_ready_a;
    logic [4:0]  read_register_b;
    logic [31:0] read_data_b;
    logic        read_ready_b;
    logic        underflow_error;

    register_file_scoreboard dut (
        .clk              (clk),
        .rst              (rst),
        .write_register   (write_register),
        .write_data       (write_data),
        .write_activate   (write_activate),
        .reserve_register (reserve_register),
        .reserve_activate (reserve_activate),
        .reserve_ready    (reserve_ready),
        .flush            (flush),
        .read_register_a  (read_register_a),
        .read_data_a      (read_data_a),
        .read_ready_a     (read_ready_a),
        .read_register_b  (read_register_b),
        .read_data_b      (read_data_b),
        .read_ready_b     (read_ready_b),
        .underflow_error  (underflow_error)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          txn   = 0;
    logic [31:0] m_mem  [32];
    int          m_pend [32];
    logic        m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 0;
        end
        m_err = 1'b0;
    endtask

    function automatic logic [31:0] exp_data(input logic [4:0] idx);
        if (idx == 0) return '0;
        if (write_activate && write_register == idx) return write_data;
        return m_mem[idx];
    endfunction

    function automatic logic exp_ready(input logic [4:0] idx);
        if (idx == 0 || m_pend[idx] == 0) return 1'b1;
        return (m_pend[idx] == 1) && write_activate && (write_register == idx);
    endfunction

    function automatic logic exp_reserve();
        if (!reserve_activate) return 1'b0;
        if (reserve_register == 0 || m_pend[reserve_register] < 3) return 1'b1;
        return write_activate && (write_register == reserve_register);
    endfunction

    // Compares every output against the model; read data only matters when final.
    task automatic compare_all(input string tag);
        logic ra, rb;
        ra = exp_ready(read_register_a);
        rb = exp_ready(read_register_b);
        check({tag, ".reserve_ready"}, {31'b0, reserve_ready}, {31'b0, exp_reserve()});
        check({tag, ".ready_a"}, {31'b0, read_ready_a}, {31'b0, ra});
        check({tag, ".ready_b"}, {31'b0, read_ready_b}, {31'b0, rb});
        if (ra) check({tag, ".data_a"}, read_data_a, exp_data(read_register_a));
        if (rb) check({tag, ".data_b"}, read_data_b, exp_data(read_register_b));
        check({tag, ".underflow"}, {31'b0, underflow_error}, {31'b0, m_err});
    endtask

    task automatic model_update();
        logic acc;
        acc = exp_reserve();
        if (write_activate && write_register != 0) m_mem[write_register] = write_data;
        if (flush) begin
            for (int r = 0; r < 32; r++) m_pend[r] = 0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                logic inc, dec;
                inc = acc && (reserve_register == r);
                dec = write_activate && (write_register == r);
                if (inc && !dec) m_pend[r]++;
                else if (dec && !inc) begin
                    if (m_pend[r] == 0) m_err = 1'b1;
                    else m_pend[r]--;
                end
            end
        end
    endtask

    task automatic set_idle();
        write_register = '0; write_data = '0; write_activate = 1'b0;
        reserve_register = '0; reserve_activate = 1'b0; flush = 1'b0;
        read_register_a = '0; read_register_b = '0;
    endtask

    // Called at a negedge with inputs already driven.
    task automatic finish_cycle(input string tag);
        #1;
        compare_all(tag);
        $display("txn %0d %s wa=%0b wr=%0d ra=%0b rr=%0d fl=%0b rdy=%0b err=%0b", txn, tag,
                 write_activate, write_register, reserve_activate, reserve_register, flush,
                 reserve_ready, underflow_error);
        txn++;
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    // Reset asserted between clock edges must take effect immediately.
    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_all(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        set_idle();
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset contents and storage latency
        read_register_a = 5;
        #1;
        check("rst.data_x5", read_data_a, 32'h0);
        check("rst.ready_x5", {31'b0, read_ready_a}, 32'h1);
        finish_cycle("rst");
        write_activate = 1'b1; write_register = 5; write_data = 32'hDEADBEEF;
        finish_cycle("wr_x5");
        set_idle(); read_register_a = 5;
        #1;
        check("x5.data", read_data_a, 32'hDEADBEEF);
        check("x5.ready", {31'b0, read_ready_a}, 32'h1);
        finish_cycle("rd_x5");
        async_reset("rst2");

        // Reservation blocks read until writeback, which bypasses
        set_idle(); reserve_activate = 1'b1; reserve_register = 3;
        finish_cycle("res_x3");
        set_idle(); read_register_a = 3;
        #1;
        check("x3.not_ready", {31'b0, read_ready_a}, 32'h0);
        finish_cycle("wait_x3");
        write_activate = 1'b1; write_register = 3; write_data = 32'h1234;
        read_register_b = 3;
        #1;
        check("x3.bypass_rdy", {31'b0, read_ready_a}, 32'h1);
        check("x3.bypass_a", read_data_a, 32'h1234);
        check("x3.bypass_b", read_data_b, 32'h1234);
        finish_cycle("wb_x3");

        // Saturation at three outstanding writes
        set_idle(); reserve_activate = 1'b1; reserve_register = 7;
        for (int i = 0; i < 3; i++) finish_cycle("res_x7");
        #1;
        check("x7.saturated", {31'b0, reserve_ready}, 32'h0);
        finish_cycle("res_x7_full");
        write_activate = 1'b1; write_register = 7; write_data = 32'hA5A5;
        #1;
        check("x7.res_with_release", {31'b0, reserve_ready}, 32'h1);
        finish_cycle("res_wb_x7");
        write_activate = 1'b0;
        #1;
        check("x7.still_full", {31'b0, reserve_ready}, 32'h0);
        finish_cycle("res_x7_full2");
        set_idle(); write_activate = 1'b1; write_register = 7;
        for (int i = 0; i < 3; i++) begin
            write_data = 32'h700 + i;
            finish_cycle("drain_x7");
        end

        // x0 is immune to writes and reservations
        set_idle(); write_activate = 1'b1; write_register = 0; write_data = 32'hFFFFFFFF;
        reserve_activate = 1'b1; reserve_register = 0;
        #1;
        check("x0.reserve_ready", {31'b0, reserve_ready}, 32'h1);
        check("x0.data", read_data_a, 32'h0);
        finish_cycle("x0");
        set_idle();
        #1;
        check("x0.data_after", read_data_a, 32'h0);
        check("x0.no_error", {31'b0, underflow_error}, 32'h0);
        finish_cycle("x0_after");

        // Flush clears pending but keeps the same-cycle write
        reserve_activate = 1'b1; reserve_register = 4;
        finish_cycle("res_x4");
        finish_cycle("res_x4");
        set_idle(); flush = 1'b1;
        write_activate = 1'b1; write_register = 4; write_data = 32'h55;
        finish_cycle("flush_wb_x4");
        set_idle(); read_register_a = 4;
        #1;
        check("x4.ready", {31'b0, read_ready_a}, 32'h1);
        check("x4.data", read_data_a, 32'h55);
        check("x4.no_error", {31'b0, underflow_error}, 32'h0);
        finish_cycle("rd_x4");

        // Unreserved writeback raises a sticky error; async reset clears it
        set_idle(); write_activate = 1'b1; write_register = 9; write_data = 32'h99;
        finish_cycle("wb_x9");
        set_idle(); read_register_a = 9;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("x9.underflow", {31'b0, underflow_error}, 32'h1);
            finish_cycle("idle");
        end
        async_reset("rst3");
        #1;
        check("rst3.error", {31'b0, underflow_error}, 32'h0);
        check("rst3.x9_data", read_data_a, 32'h0);

        // Random traffic over a small register window to provoke collisions
        @(negedge clk);
        for (int n = 0; n < 600; n++) begin
            set_idle();
            if ($urandom_range(199) == 0) begin
                async_reset("rnd_rst");
                set_idle();
            end
            reserve_activate = ($urandom_range(1) == 1);
            reserve_register = 5'($urandom_range(7));
            write_activate   = ($urandom_range(1) == 1);
            write_data       = $urandom;
            write_register   = 5'($urandom_range(7));
            if ($urandom_range(7) != 0) begin
                int start;
                start = $urandom_range(7);
                for (int k = 0; k < 8; k++) begin
                    if (m_pend[(start + k) % 8] > 0) begin
                        write_register = 5'((start + k) % 8);
                        break;
                    end
                end
            end
            flush            = ($urandom_range(31) == 0);
            read_register_a  = 5'($urandom_range(7));
            read_register_b  = ($urandom_range(3) == 0) ? read_register_a : 5'($urandom_range(7));
            finish_cycle("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
